// File: rtl/entrada_digito.sv
// Digit-entry front end for the combination lock: synchronises switches and button,
// debounces the button and strobes once per press. Optional macro: BCD_FILTER_EN.
module entrada_digito #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere_btn,
  input  logic [3:0] numero_sw,
  output logic [3:0] numero,
  output logic       digito_valido,
  output logic       ocupado,
  output logic       erro
);

  typedef enum logic [1:0] {
    OCIOSO,
    CONFIRMA_PRESS,
    PRESSIONADO,
    CONFIRMA_SOLTA
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             btn_m, btn_s;
  logic [3:0]       sw_m, sw_s;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic             bcd_ok;

`ifdef BCD_FILTER_EN
  assign bcd_ok = (sw_s <= 4'd9);
`else
  assign bcd_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= insere_btn;
      btn_s <= btn_m;
      sw_m  <= numero_sw;
      sw_s  <= sw_m;
    end
  end

  // cnt holds how many consecutive cycles btn_s has disagreed with the settled level
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    unique case (state)
      OCIOSO: begin
        if (btn_s) begin
          if (LIMIT == ONE) begin
            accept     = 1'b1;
            state_next = PRESSIONADO;
            cnt_next   = '0;
          end else begin
            state_next = CONFIRMA_PRESS;
            cnt_next   = ONE;
          end
        end
      end
      CONFIRMA_PRESS: begin
        if (!btn_s) begin
          state_next = OCIOSO;
          cnt_next   = '0;
        end else if (cnt + ONE == LIMIT) begin
          accept     = 1'b1;
          state_next = PRESSIONADO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      PRESSIONADO: begin
        if (!btn_s) begin
          if (LIMIT == ONE) begin
            state_next = OCIOSO;
            cnt_next   = '0;
          end else begin
            state_next = CONFIRMA_SOLTA;
            cnt_next   = ONE;
          end
        end
      end
      CONFIRMA_SOLTA: begin
        if (btn_s) begin
          state_next = PRESSIONADO;
          cnt_next   = '0;
        end else if (cnt + ONE == LIMIT) begin
          state_next = OCIOSO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        state_next = OCIOSO;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= OCIOSO;
      cnt           <= '0;
      numero        <= '0;
      digito_valido <= 1'b0;
      erro          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      digito_valido <= accept & bcd_ok;
      erro          <= accept & ~bcd_ok;
      if (accept && bcd_ok) numero <= sw_s;
    end
  end

  assign ocupado = (state != OCIOSO);

endmodule
